// File: rtl/instr_register_param_if.sv
// Bus bundle for instr_register_param: write/read strobes, operands and registered read data.
// wr_count/err_count exist only when INSTR_REG_STATS_EN is defined.
interface instr_register_param_if #(
    parameter int OP_W  = 32,
    parameter int DEPTH = 32
);
    localparam int AW = $clog2(DEPTH);

    logic                   load_en;
    logic [2:0]             opcode;
    logic signed [OP_W-1:0] operand_a;
    logic signed [OP_W-1:0] operand_b;
    logic [AW-1:0]          write_pointer;
    logic                   read_en;
    logic [AW-1:0]          read_pointer;

    logic [AW-1:0]            wr_ptr_out;
    logic                     rd_valid;
    logic                     rd_entry_valid;
    logic [2:0]               rd_opcode;
    logic signed [OP_W-1:0]   rd_operand_a;
    logic signed [OP_W-1:0]   rd_operand_b;
    logic signed [2*OP_W-1:0] rd_result;
    logic                     rd_div_err;
`ifdef INSTR_REG_STATS_EN
    logic [15:0]              wr_count;
    logic [15:0]              err_count;
`endif

    modport master (
        output load_en, opcode, operand_a, operand_b, write_pointer, read_en, read_pointer,
        input  wr_ptr_out, rd_valid, rd_entry_valid, rd_opcode, rd_operand_a, rd_operand_b,
        input  rd_result, rd_div_err
`ifdef INSTR_REG_STATS_EN
        , input wr_count, err_count
`endif
    );

    modport slave (
        input  load_en, opcode, operand_a, operand_b, write_pointer, read_en, read_pointer,
        output wr_ptr_out, rd_valid, rd_entry_valid, rd_opcode, rd_operand_a, rd_operand_b,
        output rd_result, rd_div_err
`ifdef INSTR_REG_STATS_EN
        , output wr_count, err_count
`endif
    );
endinterface

// File: rtl/instr_register_param.sv
// Parametrised instruction register: DEPTH entries of {opcode, operands, result, div_err}, result
// computed at write time, 1-cycle registered read. Define INSTR_REG_STATS_EN for write/error counters.
module instr_register_param #(
    parameter int OP_W     = 32,
    parameter int DEPTH    = 32,
    parameter bit AUTO_INC = 1'b0
) (
    input logic                   clk,
    input logic                   reset_n,
    instr_register_param_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int RW = 2 * OP_W;

    localparam logic [2:0] OP_ZERO  = 3'd0;
    localparam logic [2:0] OP_PASSA = 3'd1;
    localparam logic [2:0] OP_PASSB = 3'd2;
    localparam logic [2:0] OP_ADD   = 3'd3;
    localparam logic [2:0] OP_SUB   = 3'd4;
    localparam logic [2:0] OP_MULT  = 3'd5;
    localparam logic [2:0] OP_DIV   = 3'd6;
    localparam logic [2:0] OP_MOD   = 3'd7;

    // Operands are widened first so MULT keeps the full product and MIN/-1 cannot overflow.
    function automatic logic [RW:0] calc_entry(input logic [2:0] op,
                                               input logic signed [OP_W-1:0] a,
                                               input logic signed [OP_W-1:0] b);
        logic signed [RW-1:0] ax;
        logic signed [RW-1:0] bx;
        logic signed [RW-1:0] r;
        logic                 err;
        ax  = {{OP_W{a[OP_W-1]}}, a};
        bx  = {{OP_W{b[OP_W-1]}}, b};
        r   = '0;
        err = 1'b0;
        case (op)
            OP_ZERO:  r = '0;
            OP_PASSA: r = ax;
            OP_PASSB: r = bx;
            OP_ADD:   r = ax + bx;
            OP_SUB:   r = ax - bx;
            OP_MULT:  r = ax * bx;
            OP_DIV:   if (b == '0) err = 1'b1; else r = ax / bx;
            OP_MOD:   if (b == '0) err = 1'b1; else r = ax % bx;
        endcase
        return {err, r};
    endfunction

    logic [2:0]             opc_mem [DEPTH];
    logic signed [OP_W-1:0] a_mem   [DEPTH];
    logic signed [OP_W-1:0] b_mem   [DEPTH];
    logic signed [RW-1:0]   res_mem [DEPTH];

    logic [DEPTH-1:0]     valid_q;
    logic [DEPTH-1:0]     div_err_q;
    logic [AW-1:0]        wr_ptr_q;
    logic [AW-1:0]        wr_ptr_d;
    logic [AW-1:0]        wr_addr;
    logic [AW-1:0]        rd_addr;
    logic [RW:0]          calc;
    logic signed [RW-1:0] wr_result;
    logic                 wr_err;

    logic                   rd_valid_q;
    logic                   rd_entry_valid_q;
    logic [2:0]             rd_opcode_q;
    logic signed [OP_W-1:0] rd_operand_a_q;
    logic signed [OP_W-1:0] rd_operand_b_q;
    logic signed [RW-1:0]   rd_result_q;
    logic                   rd_div_err_q;

    always_comb begin
        calc      = calc_entry(bus.opcode, bus.operand_a, bus.operand_b);
        wr_err    = calc[RW];
        wr_result = calc[RW-1:0];
        wr_addr   = AUTO_INC ? wr_ptr_q : bus.write_pointer;
        rd_addr   = bus.read_pointer;
        wr_ptr_d  = wr_ptr_q;
        if (AUTO_INC && bus.load_en) wr_ptr_d = wr_ptr_q + AW'(1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q   <= '0;
            div_err_q <= '0;
            wr_ptr_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            if (bus.load_en) begin
                valid_q[wr_addr]   <= 1'b1;
                div_err_q[wr_addr] <= wr_err;
            end
        end
    end

    // Payload storage is not reset; the valid bit masks stale contents on read.
    always_ff @(posedge clk) begin
        if (bus.load_en) begin
            opc_mem[wr_addr] <= bus.opcode;
            a_mem[wr_addr]   <= bus.operand_a;
            b_mem[wr_addr]   <= bus.operand_b;
            res_mem[wr_addr] <= wr_result;
        end
    end

    // Read samples pre-edge contents, so a same-cycle write to rd_addr is not yet visible.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_valid_q       <= 1'b0;
            rd_entry_valid_q <= 1'b0;
            rd_opcode_q      <= '0;
            rd_operand_a_q   <= '0;
            rd_operand_b_q   <= '0;
            rd_result_q      <= '0;
            rd_div_err_q     <= 1'b0;
        end else begin
            rd_valid_q <= bus.read_en;
            if (bus.read_en) begin
                rd_entry_valid_q <= valid_q[rd_addr];
                rd_div_err_q     <= div_err_q[rd_addr];
                if (valid_q[rd_addr]) begin
                    rd_opcode_q    <= opc_mem[rd_addr];
                    rd_operand_a_q <= a_mem[rd_addr];
                    rd_operand_b_q <= b_mem[rd_addr];
                    rd_result_q    <= res_mem[rd_addr];
                end else begin
                    rd_opcode_q    <= '0;
                    rd_operand_a_q <= '0;
                    rd_operand_b_q <= '0;
                    rd_result_q    <= '0;
                end
            end
        end
    end

    assign bus.wr_ptr_out     = AUTO_INC ? wr_ptr_q : '0;
    assign bus.rd_valid       = rd_valid_q;
    assign bus.rd_entry_valid = rd_entry_valid_q;
    assign bus.rd_opcode      = rd_opcode_q;
    assign bus.rd_operand_a   = rd_operand_a_q;
    assign bus.rd_operand_b   = rd_operand_b_q;
    assign bus.rd_result      = rd_result_q;
    assign bus.rd_div_err     = rd_div_err_q;

`ifdef INSTR_REG_STATS_EN
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [15:0] wr_cnt_q;
    logic [15:0] err_cnt_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_cnt_q  <= '0;
            err_cnt_q <= '0;
        end else if (bus.load_en) begin
            wr_cnt_q <= sat_inc(wr_cnt_q);
            if (wr_err) err_cnt_q <= sat_inc(err_cnt_q);
        end
    end

    assign bus.wr_count  = wr_cnt_q;
    assign bus.err_count = err_cnt_q;
`endif
endmodule

// File: doc/instr_register_param.md
Name: instr_register_param

Overview:
- Parametrised next-generation instruction register: stores DEPTH instruction words {opcode, operand_a, operand_b, result, flags}.
- Computes the result at write time.
- Supports explicit or auto-incrementing write addressing.
- Registered 1-cycle read port with valid qualifier.
- Sits between the instruction-issue bench/driver and downstream checkers; replaces the fixed 32-bit, 32-entry register.

Parameters:
OP_W, 32, operand width in bits (signed two's complement); result width is 2*OP_W
DEPTH, 32, number of entries; power of two, 2..256
AUTO_INC, 0, 1 = internal write pointer (write_pointer input ignored), 0 = write_pointer input used

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous active-low reset
load_en  in  1  write strobe
opcode  in  3  0 ZERO, 1 PASSA, 2 PASSB, 3 ADD, 4 SUB, 5 MULT, 6 DIV, 7 MOD
operand_a  in  OP_W  signed operand A
operand_b  in  OP_W  signed operand B
write_pointer  in  AW  write address; AW = $clog2(DEPTH)
read_en  in  1  read strobe
read_pointer  in  AW  read address
wr_ptr_out  out  AW  next auto-increment address (AUTO_INC=1); 0 otherwise
rd_valid  out  1  read data valid, 1 cycle after read_en
rd_entry_valid  out  1  addressed entry has been written since reset
rd_opcode  out  3  stored opcode
rd_operand_a  out  OP_W  stored operand A
rd_operand_b  out  OP_W  stored operand B
rd_result  out  2*OP_W  stored signed result
rd_div_err  out  1  stored divide/modulo-by-zero flag

Behaviour:
- Reset (async assert, sync release): all entries' valid bits, div_err bits and all outputs = 0; internal write pointer = 0. Storage contents need not be cleared, but an unwritten entry reads as all-zero fields.
- Write (load_en=1 at clk edge): the entry at the address is written with opcode, operands, result and div_err. The address is write_pointer (AUTO_INC=0) or the internal pointer (AUTO_INC=1). The entry's valid bit is set.
- Result arithmetic: all results are signed, sign-extended to 2*OP_W.
  - ZERO -> 0; PASSA -> a; PASSB -> b; ADD -> a+b; SUB -> a-b; MULT -> a*b (full 2*OP_W product).
  - DIV -> a/b, truncated toward zero; MOD -> a%b, sign of a.
  - DIV/MOD with b=0 -> result 0, div_err=1. Otherwise div_err=0.
- Auto-increment: on each write the internal pointer increments by 1 and wraps DEPTH-1 -> 0, overwriting the oldest entry. wr_ptr_out shows the pointer value. No increment without load_en.
- Read: read_en=1 at edge N -> at edge N+1:
  - rd_valid=1;
  - rd_* fields = entry[read_pointer] as it was before edge N's write;
  - rd_entry_valid = that entry's valid bit.
- read_en=0 -> rd_valid=0 next cycle; rd_* fields hold their last values.
- Simultaneous read and write to the same address in one cycle: the read returns the old contents (read-before-write). The new value is visible from the following read.
- Reset mid-operation: an in-flight read is discarded (rd_valid=0); pending state is lost; the pointer returns to 0.
- Back-to-back reads every cycle are supported, giving throughput of 1 read and 1 write per cycle.

Optional Feature:
Macro INSTR_REG_STATS_EN.
- Defined: adds output ports wr_count[15:0] and err_count[15:0].
  - wr_count increments on every write.
  - err_count increments on every write with div_err=1.
  - Both saturate at 16'hFFFF and reset to 0.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset then read addr 0..DEPTH-1 -> every read: rd_valid=1, rd_entry_valid=0, all fields 0.
- AUTO_INC=0: write addr 5, ADD, a=7, b=-3; then read 5 -> rd_result=4, rd_opcode=3, rd_entry_valid=1, rd_div_err=0, returned exactly 1 cycle after read_en.
- Arithmetic sweep at OP_W=32:
  - MULT a=32'h7FFFFFFF, b=2 -> rd_result=64'h00000000FFFFFFFE;
  - DIV a=-7, b=2 -> -3;
  - MOD a=-7, b=2 -> -1;
  - DIV a=9, b=0 -> result 0, rd_div_err=1.
- AUTO_INC=1, DEPTH=4: 5 writes with PASSA a=10,11,12,13,14 -> wr_ptr_out=1; reads of 0..3 return 14,11,12,13.
- Same-cycle write addr 2 (PASSB b=99) and read addr 2 holding 50 -> read returns 50; the next read of 2 returns 99.
- reset_n asserted the cycle after read_en -> rd_valid=0 immediately; all rd_* fields=0. With INSTR_REG_STATS_EN: 3 writes including 1 div-by-zero -> wr_count=3, err_count=1; after reset both are 0.
